vsfx_wb: RTL and testbench

- Result writeback buffer on the consumer side of the vector simple fixed-point unit.
- Accepts per-cycle results (vrt_en, vrt, sat, cr6) plus destination register index and CR6 record flag, and queues them in a small in-order FIFO.
- Drains the queue to the vector register file write port over a valid/ready handshake.
- Maintains the sticky VSCR[SAT] bit and commits CR6 in retirement order.

---
 rtl/vsfx_pkg.sv | 11 +
 rtl/vsfx_wb_fifo.sv | 52 +++++
 rtl/vsfx_wb.sv | 78 +++++++
 tb/tb_vsfx_wb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsfx_pkg.sv
// Shared widths for the vsfx result writeback path.
// A writeback entry is packed as {addr, data, cr6, cr6_en}.
package vsfx_pkg;
  localparam int VR_W   = 128;
  localparam int CR_W   = 4;
  localparam int AW_DEF = 5;

  function automatic int entry_w(input int aw);
    return aw + VR_W + CR_W + 1;
  endfunction
endpackage

// File: rtl/vsfx_wb_fifo.sv
// Generic in-order synchronous FIFO with flush.
// The head word is read straight from storage, so a push never bypasses to dout.
module vsfx_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/vsfx_wb.sv
// Writeback buffer between the vsfx unit and the VR file write port.
// SAT is accumulated at acceptance; CR6 is committed in retirement order.
module vsfx_wb
  import vsfx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vrt_en,
  input  logic [VR_W-1:0] vrt,
  input  logic            sat,
  input  logic [CR_W-1:0] cr6,
  input  logic            cr6_en,
  input  logic [AW-1:0]   vrt_addr,
  input  logic            flush,
  input  logic            vscr_sat_clr,
  input  logic            vrf_ready,
  output logic            vrf_we,
  output logic [AW-1:0]   vrf_waddr,
  output logic [VR_W-1:0] vrf_wdata,
  output logic            vscr_sat,
  output logic [CR_W-1:0] cr6_out,
  output logic            cr6_we,
  output logic            stall,
  output logic            ovf
);
  localparam int EW = entry_w(AW);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [EW-1:0]   head;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push_ok;
  logic [CR_W-1:0] head_cr6;
  logic            head_cr6_en;

  // Gating with rst keeps a write from completing in the reset cycle.
  assign vrf_we  = !empty && !rst;
  assign pop     = vrf_we && vrf_ready;
  assign push_ok = vrt_en && !flush && (!full || pop);
  assign stall   = (count >= CW'(DEPTH - 1));
  assign {vrf_waddr, vrf_wdata, head_cr6, head_cr6_en} = head;

  vsfx_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .flush (flush),
    .din   ({vrt_addr, vrt, cr6, cr6_en}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vscr_sat <= 1'b0;
      cr6_out  <= '0;
      cr6_we   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      cr6_we <= pop && !flush && head_cr6_en;
      if (pop && !flush && head_cr6_en) cr6_out <= head_cr6;
      if (push_ok && sat)    vscr_sat <= 1'b1;
      else if (vscr_sat_clr) vscr_sat <= 1'b0;
      if (vrt_en && !flush && full && !pop) ovf <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vsfx_wb.sv
// Bench for vsfx_wb: queue-based reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_vsfx_wb;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         vrt_en;
  logic [127:0] vrt;
  logic         sat;
  logic [3:0]   cr6;
  logic         cr6_en;
  logic [4:0]   vrt_addr;
  logic         flush;
  logic         vscr_sat_clr;
  logic         vrf_ready;
  logic         vrf_we;
  logic [4:0]   vrf_waddr;
  logic [127:0] vrf_wdata;
  logic         vscr_sat;
  logic [3:0]   cr6_out;
  logic         cr6_we;
  logic         stall;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  vsfx_wb #(.DEPTH(DEPTH), .AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .vrt_en       (vrt_en),
    .vrt          (vrt),
    .sat          (sat),
    .cr6          (cr6),
    .cr6_en       (cr6_en),
    .vrt_addr     (vrt_addr),
    .flush        (flush),
    .vscr_sat_clr (vscr_sat_clr),
    .vrf_ready    (vrf_ready),
    .vrf_we       (vrf_we),
    .vrf_waddr    (vrf_waddr),
    .vrf_wdata    (vrf_wdata),
    .vscr_sat     (vscr_sat),
    .cr6_out      (cr6_out),
    .cr6_we       (cr6_we),
    .stall        (stall),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: architectural queue plus sticky state
  typedef struct {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [3:0]   cr6;
    logic         cr6_en;
  } ent_t;

  ent_t       q[$];
  ent_t       h;
  logic       m_sat = 1'b0;
  logic [3:0] m_cr6 = 4'h0;
  logic       m_cr6we = 1'b0;
  logic       m_ovf = 1'b0;
  bit         model_on = 1'b0;
  bit         m_pop;
  bit         m_acc;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_sat    = 1'b0;
      m_cr6    = 4'h0;
      m_cr6we  = 1'b0;
      m_ovf    = 1'b0;
      model_on = 1'b1;
    end else begin
      m_cr6we = 1'b0;
      if (flush) begin
        q.delete();
        if (vscr_sat_clr) m_sat = 1'b0;
      end else begin
        m_pop = (q.size() != 0) && vrf_ready;
        m_acc = vrt_en && ((q.size() < DEPTH) || m_pop);
        if (vrt_en && !m_acc) m_ovf = 1'b1;
        if (m_pop) begin
          h = q.pop_front();
          if (h.cr6_en) begin
            m_cr6   = h.cr6;
            m_cr6we = 1'b1;
          end
        end
        if (m_acc) q.push_back('{vrt_addr, vrt, cr6, cr6_en});
        if (m_acc && sat)      m_sat = 1'b1;
        else if (vscr_sat_clr) m_sat = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    if (model_on) begin
      chk("m_vrf_we", vrf_we, ((q.size() != 0) && !rst));
      if ((q.size() != 0) && !rst) begin
        chk("m_waddr", vrf_waddr, q[0].addr);
        chk("m_wdata", vrf_wdata, q[0].data);
      end
      chk("m_cr6_out", cr6_out, m_cr6);
      chk("m_cr6_we", cr6_we, m_cr6we);
      chk("m_vscr_sat", vscr_sat, m_sat);
      chk("m_ovf", ovf, m_ovf);
      chk("m_stall", stall, (q.size() >= DEPTH - 1));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle();
    vrt_en = 0; sat = 0; cr6_en = 0; cr6 = 0; flush = 0; vscr_sat_clr = 0;
    vrt = '0; vrt_addr = '0;
  endtask

  task automatic put(input logic [4:0] a, input logic [127:0] d, input logic s,
                     input logic ce, input logic [3:0] c);
    vrt_en = 1; vrt_addr = a; vrt = d; sat = s; cr6_en = ce; cr6 = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [127:0] d1;
    d1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    idle();
    rst = 1; vrf_ready = 0;
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst_we", vrf_we, 1'b0);
    chk("rst_sat", vscr_sat, 1'b0);
    chk("rst_cr6", cr6_out, 4'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_stall", stall, 1'b0);

    // single push, drained immediately
    put(5'd3, d1, 0, 0, 4'h0); vrf_ready = 1;
    cyc();
    chk("single_we", vrf_we, 1'b1);
    chk("single_addr", vrf_waddr, 5'd3);
    chk("single_data", vrf_wdata, d1);
    idle();
    cyc();
    chk("single_empty", vrf_we, 1'b0);
    chk("single_cr6we", cr6_we, 1'b0);

    // fill with no ready, overflow, then ordered drain
    vrf_ready = 0;
    for (int i = 0; i < 4; i++) begin
      put(5'(i), {4{i}}, 0, 0, 4'h0);
      cyc();
      if (i == 1) chk("stall_two", stall, 1'b0);
      if (i == 2) chk("stall_three", stall, 1'b1);
    end
    put(5'd9, d1, 0, 0, 4'h0);
    cyc();
    chk("ovf_set", ovf, 1'b1);
    idle(); vrf_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", vrf_we, 1'b1);
      chk("drain_addr", vrf_waddr, 5'(i));
      cyc();
    end
    chk("drain_done", vrf_we, 1'b0);

    rst = 1; cyc(); rst = 0; cyc();
    chk("ovf_cleared", ovf, 1'b0);

    // full FIFO: push and pop in the same cycle
    vrf_ready = 0;
    for (int i = 0; i < 4; i++) begin
      put(5'(10 + i), {4{i + 100}}, 0, 0, 4'h0);
      cyc();
    end
    put(5'd14, d1, 0, 0, 4'h0); vrf_ready = 1;
    cyc();
    chk("full_pp_ovf", ovf, 1'b0);
    chk("full_pp_stall", stall, 1'b1);
    chk("full_pp_head", vrf_waddr, 5'd11);
    idle();
    cyc(); cyc(); cyc();
    chk("full_pp_tail", vrf_waddr, 5'd14);
    cyc();
    chk("full_pp_empty", vrf_we, 1'b0);

    // sticky SAT: set beats clear, clear alone, survives flush
    put(5'd1, d1, 1, 0, 4'h0); vscr_sat_clr = 1;
    cyc();
    chk("sat_set_wins", vscr_sat, 1'b1);
    idle(); vscr_sat_clr = 1;
    cyc();
    chk("sat_clr", vscr_sat, 1'b0);
    idle(); vrf_ready = 0;
    put(5'd2, d1, 1, 0, 4'h0);
    cyc();
    chk("sat_accept", vscr_sat, 1'b1);
    idle(); flush = 1;
    cyc();
    chk("sat_after_flush", vscr_sat, 1'b1);
    chk("flush_we", vrf_we, 1'b0);
    idle();

    // CR6 commits only when the record entry retires
    put(5'd4, d1, 0, 0, 4'h0); cyc();
    put(5'd5, d1, 0, 0, 4'h0); cyc();
    put(5'd6, d1, 0, 1, 4'b1000); cyc();
    idle(); vrf_ready = 1;
    cyc();
    chk("cr6_pop1_we", cr6_we, 1'b0);
    chk("cr6_pop1_val", cr6_out, 4'h0);
    cyc();
    chk("cr6_pop2_we", cr6_we, 1'b0);
    cyc();
    chk("cr6_pop3_we", cr6_we, 1'b1);
    chk("cr6_pop3_val", cr6_out, 4'b1000);
    cyc();
    chk("cr6_pulse_end", cr6_we, 1'b0);
    chk("cr6_hold", cr6_out, 4'b1000);

    // reset mid-drain
    put(5'd7, d1, 1, 1, 4'b0110); cyc();
    idle(); cyc();
    chk("pre_rst_cr6", cr6_out, 4'b0110);
    chk("pre_rst_sat", vscr_sat, 1'b1);
    vrf_ready = 0;
    put(5'd8, d1, 0, 0, 4'h0); cyc();
    put(5'd9, d1, 0, 0, 4'h0); cyc();
    idle(); rst = 1; vrf_ready = 1;
    cyc();
    chk("rst_mid_we", vrf_we, 1'b0);
    chk("rst_mid_cr6", cr6_out, 4'h0);
    chk("rst_mid_sat", vscr_sat, 1'b0);
    rst = 0;
    cyc();
    chk("rst_mid_empty", vrf_we, 1'b0);
    chk("rst_mid_stall", stall, 1'b0);

    // flush with three queued entries
    put(5'd1, d1, 0, 1, 4'b0011); cyc();
    idle(); cyc();
    chk("pre_flush_cr6", cr6_out, 4'b0011);
    vrf_ready = 0;
    for (int i = 0; i < 3; i++) begin
      put(5'(20 + i), {4{i + 7}}, 0, 1, 4'b1111);
      cyc();
    end
    chk("pre_flush_stall", stall, 1'b1);
    idle(); flush = 1; vrf_ready = 1;
    cyc();
    chk("flush3_we", vrf_we, 1'b0);
    chk("flush3_cr6", cr6_out, 4'b0011);
    chk("flush3_cr6we", cr6_we, 1'b0);
    flush = 0;
    cyc();
    chk("flush3_stall", stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
